// File: rtl/adc_sample_packer.sv
// adc_sample_packer: captures multi-channel ADC samples and streams them out
// as formatted per-channel beats, lowest enabled channel first.
module adc_sample_packer #(
  parameter int ADC_W  = 14,
  parameter int OUT_W  = 16,
  parameter int NUM_CH = 2,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic                    fmt_offset,
  input  logic                    test_mode,
  input  logic                    sample_valid,
  input  logic [NUM_CH*ADC_W-1:0] sample_data,
  output logic [OUT_W-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow,
  input  logic                    overflow_clr
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_nx;
  logic [NUM_CH*ADC_W-1:0] data_q;
  logic [NUM_CH-1:0] rem, low;
  logic [ADC_W-1:0] cnt, raw;
  logic fmt_q, accept, last_acc, capture, drop;
  // rem holds the channels still to be sent; its lowest set bit is the current beat
  assign low       = rem & -rem;
  assign out_valid = state == EMIT;
  assign out_last  = out_valid && rem == low;
  assign accept    = out_valid & out_ready;
  assign last_acc  = accept & out_last;
  assign capture   = sample_valid & en & |ch_mask & (!out_valid | last_acc);
  assign drop      = sample_valid & en & |ch_mask & out_valid & !last_acc;
  always_comb begin
    out_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (rem[i]) out_ch = CH_W'(i);
  end
  assign raw = data_q[out_ch*ADC_W +: ADC_W];
  // offset-binary to two's complement is an MSB flip; the flipped MSB is also the sign
  assign out_data = fmt_q ? {{(OUT_W-ADC_W+1){~raw[ADC_W-1]}}, raw[ADC_W-2:0]} : OUT_W'(raw);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = capture ? EMIT : last_acc ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data_q   <= '0;
      rem      <= '0;
      fmt_q    <= 1'b0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (capture) begin
        data_q <= test_mode ? {NUM_CH{cnt}} : sample_data;
        rem    <= ch_mask;
        fmt_q  <= fmt_offset;
      end else if (accept) rem <= rem & ~low;
      cnt      <= !en ? '0 : capture ? cnt + 1'b1 : cnt;
      overflow <= drop | (overflow & !overflow_clr);
    end
endmodule

// File: tb/tb_adc_sample_packer.sv
// tb_adc_sample_packer: vector table plus directed sequences, checked by a beat scoreboard.
module tb_adc_sample_packer;
  localparam int ADC_W = 14, OUT_W = 16, NUM_CH = 2, CH_W = 1;
  logic clk = 0, reset_n = 0, en = 0, fmt_offset = 0, test_mode = 0;
  logic sample_valid = 0, out_ready = 1, overflow_clr = 0;
  logic [NUM_CH-1:0] ch_mask = '0;
  logic [NUM_CH*ADC_W-1:0] sample_data = '0;
  logic [OUT_W-1:0] out_data;
  logic [CH_W-1:0] out_ch;
  logic out_last, out_valid, overflow;
  int tests = 0, fails = 0;

  typedef struct {logic [OUT_W-1:0] data; logic ch; logic last;} beat_t;
  typedef struct {logic [1:0] m; logic f; logic [ADC_W-1:0] d0, d1; logic [OUT_W-1:0] e0, e1;} vec_t;
  beat_t sb[$];
  vec_t v[6];

  adc_sample_packer #(.ADC_W(ADC_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .ch_mask(ch_mask), .fmt_offset(fmt_offset),
    .test_mode(test_mode), .sample_valid(sample_valid), .sample_data(sample_data),
    .out_data(out_data), .out_ch(out_ch), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [OUT_W-1:0] d, logic c, logic l);
    beat_t b;
    b.data = d;
    b.ch = c;
    b.last = l;
    sb.push_back(b);
  endtask

  task automatic pulse();
    sample_valid = 1;
    tick();
    sample_valid = 0;
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check({name, "_drain"}, sb.size(), 0);
    tick();
    check({name, "_idle"}, {31'b0, out_valid}, 0);
  endtask

  always @(negedge clk) begin
    beat_t b;
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_beat", {31'b0, out_valid}, 0);
      else begin
        b = sb.pop_front();
        check("sb_data", {16'b0, out_data}, {16'b0, b.data});
        check("sb_ch", {31'b0, out_ch}, {31'b0, b.ch});
        check("sb_last", {31'b0, out_last}, {31'b0, b.last});
      end
    end
  end

  initial begin
    v[0] = '{2'b11, 1'b0, 14'h1234, 14'h3FFF, 16'h1234, 16'h3FFF};
    v[1] = '{2'b11, 1'b1, 14'h0000, 14'h3FFF, 16'hE000, 16'h1FFF};
    v[2] = '{2'b01, 1'b1, 14'h2000, 14'h0000, 16'h0000, 16'h0000};
    v[3] = '{2'b10, 1'b0, 14'h0AAA, 14'h1555, 16'h0000, 16'h1555};
    v[4] = '{2'b11, 1'b1, 14'h1FFF, 14'h2001, 16'hFFFF, 16'h0001};
    v[5] = '{2'b10, 1'b1, 14'h0000, 14'h0001, 16'h0000, 16'hE001};

    #12;
    check("rst_valid", {31'b0, out_valid}, 0);
    check("rst_data", {16'b0, out_data}, 0);
    check("rst_ch", {31'b0, out_ch}, 0);
    check("rst_last", {31'b0, out_last}, 0);
    check("rst_ovf", {31'b0, overflow}, 0);

    @(posedge clk);
    #1;
    en = 1; ch_mask = 2'b11; fmt_offset = 0;
    sample_data = {14'h3FFF, 14'h1234};
    push(16'h1234, 0, 0);
    push(16'h3FFF, 1, 1);
    sample_valid = 1;
    reset_n = 1;
    tick();
    sample_valid = 0;
    check("basic_n1_valid", {31'b0, out_valid}, 1);
    check("basic_n1_data", {16'b0, out_data}, 32'h1234);
    check("basic_n1_last", {31'b0, out_last}, 0);
    tick();
    check("basic_n2_valid", {31'b0, out_valid}, 1);
    check("basic_n2_ch", {31'b0, out_ch}, 1);
    check("basic_n2_last", {31'b0, out_last}, 1);
    tick();
    check("basic_n3_valid", {31'b0, out_valid}, 0);
    check("basic_sb", sb.size(), 0);

    for (int i = 0; i < 6; i++) begin
      ch_mask = v[i].m;
      fmt_offset = v[i].f;
      sample_data = {v[i].d1, v[i].d0};
      if (v[i].m[0]) push(v[i].e0, 1'b0, !v[i].m[1]);
      if (v[i].m[1]) push(v[i].e1, 1'b1, 1'b1);
      pulse();
      drain($sformatf("vec%0d", i));
    end

    out_ready = 0; fmt_offset = 0; ch_mask = 2'b11;
    sample_data = {14'h0DEF, 14'h0ABC};
    push(16'h0ABC, 0, 0);
    push(16'h0DEF, 1, 1);
    sample_valid = 1;
    tick();
    sample_data = {14'h1111, 14'h2222};
    check("bp_valid", {31'b0, out_valid}, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      sample_valid = 0;
      check("bp_hold_valid", {31'b0, out_valid}, 1);
      check("bp_hold_data", {16'b0, out_data}, 32'h0ABC);
      check("bp_hold_ch", {31'b0, out_ch}, 0);
      check("bp_hold_last", {31'b0, out_last}, 0);
    end
    check("bp_ovf_set", {31'b0, overflow}, 1);
    out_ready = 1;
    drain("bp");
    overflow_clr = 1;
    tick();
    overflow_clr = 0;
    check("bp_ovf_clr", {31'b0, overflow}, 0);

    sample_data = {14'h0002, 14'h0001};
    push(16'h0001, 0, 0);
    push(16'h0002, 1, 1);
    pulse();
    tick();
    check("b2b_a_ch1", {31'b0, out_ch}, 1);
    sample_data = {14'h0004, 14'h0003};
    push(16'h0003, 0, 0);
    push(16'h0004, 1, 1);
    pulse();
    check("b2b_b_valid", {31'b0, out_valid}, 1);
    check("b2b_b_ch", {31'b0, out_ch}, 0);
    check("b2b_b_data", {16'b0, out_data}, 32'h0003);
    check("b2b_ovf", {31'b0, overflow}, 0);
    drain("b2b");

    ch_mask = 2'b00;
    pulse();
    for (int i = 0; i < 3; i++) begin
      check("mask0_valid", {31'b0, out_valid}, 0);
      tick();
    end
    check("mask0_ovf", {31'b0, overflow}, 0);

    en = 0;
    tick();
    en = 1; test_mode = 1; ch_mask = 2'b11; fmt_offset = 0;
    sample_data = {14'h1555, 14'h2AAA};
    for (int k = 0; k < 3; k++) begin
      push(16'(k), 0, 0);
      push(16'(k), 1, 1);
      pulse();
      drain($sformatf("tm%0d", k));
    end
    en = 0;
    tick();
    en = 1; ch_mask = 2'b01; sample_valid = 1;
    for (int k = 0; k < 16383; k++) begin
      push(16'(k), 0, 1);
      tick();
    end
    sample_valid = 0;
    drain("preload");
    ch_mask = 2'b11;
    push(16'h3FFF, 0, 0);
    push(16'h3FFF, 1, 1);
    pulse();
    drain("tm_max");
    push(16'h0000, 0, 0);
    push(16'h0000, 1, 1);
    pulse();
    drain("tm_wrap");

    test_mode = 0;
    sample_data = {14'h0111, 14'h0222};
    push(16'h0222, 0, 0);
    pulse();
    tick();
    check("rmf_pre_ch", {31'b0, out_ch}, 1);
    reset_n = 0;
    #1;
    check("rmf_valid", {31'b0, out_valid}, 0);
    check("rmf_data", {16'b0, out_data}, 0);
    check("rmf_ch", {31'b0, out_ch}, 0);
    check("rmf_last", {31'b0, out_last}, 0);
    check("rmf_ovf", {31'b0, overflow}, 0);
    tick();
    reset_n = 1;
    tick();
    check("rmf_idle", {31'b0, out_valid}, 0);
    check("rmf_sb", sb.size(), 0);
    test_mode = 1;
    push(16'h0000, 0, 0);
    push(16'h0000, 1, 1);
    pulse();
    drain("rmf_cnt");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
